statistic_bank: RTL and testbench
=================================

Name: statistic_bank

Overview:
- Parametrised successor to the pipeline statistic unit.
- Counts total run cycles plus NUM_EVT independent event channels (e.g. unconditional branch, conditional branch, conditional taken, load-use stall).
- Decodes syscalls for display, halt and pause, and exposes all counters through a registered indexed read port.
- Sits beside the WB stage; event strobes come from the pipeline, outputs drive the board display and the halt line.

Parameters:
- NUM_EVT, 4, number of event counter channels (1..15).
- CNT_W, 32, width of every counter.
- SAT, 0, overflow mode: 0 = wrap to 0, 1 = saturate at all-ones.
- SC_HALT, 10, syscall code (A value) that halts.
- SC_SHOW, 34, syscall code that latches B into syscall_out.
- SC_PAUSE, 50, syscall code that pauses until go.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- A  in  32  syscall code operand ($v0).
- B  in  32  syscall data operand ($a0).
- syscall_t  in  1  syscall retiring this cycle.
- strong_halt  in  1  unconditional halt request.
- evt_in  in  NUM_EVT  per-channel event strobe; bit i is counted once per cycle when high.
- clr  in  1  synchronous clear of all counters and overflow flags.
- go  in  1  resume pulse out of PAUSE.
- rd_sel  in  4  read select: 0 = cycle counter, 1..NUM_EVT = channel rd_sel-1.
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit i+1 = channel i.
- syscall_out  out  32  last value shown.
- halt  out  1  high while in HALT.
- paused  out  1  high while in PAUSE.

Behaviour:
- Reset: asynchronous, when rst=0. All counters, ovf, syscall_out and rd_data are 0; halt=0, paused=0; state RUN. Reset mid-operation, including in HALT or PAUSE, returns to RUN with everything cleared.
- States:
  - RUN: cycle counter +1 every cycle; channel i +1 when evt_in[i]=1.
  - PAUSE: all counters hold; evt_in is ignored.
  - HALT: all counters hold; HALT is terminal until reset.
- Transitions are evaluated on each clk edge in RUN, in priority order:
  1. strong_halt=1 -> HALT.
  2. syscall_t=1 and A==SC_HALT -> HALT.
  3. syscall_t=1 and A==SC_PAUSE -> PAUSE.
  4. Otherwise stay in RUN.
- PAUSE -> RUN on go=1. strong_halt=1 in PAUSE -> HALT, and strong_halt wins over a simultaneous go.
- The triggering cycle still counts: cycle and events in the cycle that requests HALT or PAUSE are added. halt and paused rise the following cycle (registered).
- Display: syscall_t=1 and A==SC_SHOW in RUN -> syscall_out <= B on that edge. Syscalls with any other A are ignored, and syscalls outside RUN are ignored.
- Overflow:
  - An increment from all-ones sets that channel's ovf bit (sticky).
  - SAT=0: the counter wraps to 0.
  - SAT=1: the counter stays at all-ones.
- clr=1 zeroes all counters and ovf in any state; it does not change state or syscall_out. clr has priority over a same-cycle increment, so the result is 0, not 1.
- Read port: rd_data <= selected counter with a 1-cycle latency. It returns the pre-update value of the cycle in which rd_sel is sampled. rd_sel > NUM_EVT returns 0.
- All arithmetic is unsigned CNT_W. There are no multi-cycle paths.

Decomposition:
- Shared package stat_pkg:
  - state enum (RUN, PAUSE, HALT) as 2-bit localparams;
  - default syscall code constants;
  - RD_SEL_W = 4.
- One sub-module, stat_counter: a single CNT_W counter with inc, clr, hold and SAT inputs, returning count and sticky ovf. It is instantiated NUM_EVT+1 times via generate.

Test Plan:
- Reset release and counting:
  - Stimulus: release rst at t=10ns, then 20 clocks with evt_in=4'b0101.
  - Required: rd_sel=0 -> 20, rd_sel=1 -> 20, rd_sel=2 -> 0, rd_sel=3 -> 20.
- Display then halt:
  - Stimulus: syscall_t with A=34, B=123, then later syscall_t with A=10 at cycle 30.
  - Required: syscall_out=123; halt=1 from cycle 31; cycle counter frozen at 31 across 10 further clocks.
- Pause and resume:
  - Stimulus: syscall_t with A=50 at cycle 5, go at cycle 12, evt_in held at 1.
  - Required: paused during cycles 6..12; counters advance only outside PAUSE; final counts differ from elapsed cycles by 7.
- Overflow, wrap build (CNT_W=4, SAT=0):
  - Stimulus: 17 events on channel 0.
  - Required: count=1, ovf[1]=1.
- Overflow, saturate build (CNT_W=4, SAT=1):
  - Stimulus: 17 events on channel 0.
  - Required: count=15, ovf[1]=1.
- Clear priority and reset:
  - Stimulus: clr together with evt_in=all-ones.
  - Required: all counters 0 next cycle.
  - Stimulus: assert rst in HALT.
  - Required: halt=0 asynchronously and rd_data=0.

Source files
------------

// File: rtl/stat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stat_pkg
//  Description : Shared types and constants for the statistic bank.
//                - state_e     : operating state of the bank (RUN/PAUSE/HALT)
//                - SC_*_DEF    : default syscall codes ($v0 values)
//                - RD_SEL_W    : width of the indexed read select
//  Revision    : 1.0  initial release
// ============================================================================
package stat_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [31:0] SC_HALT_DEF  = 32'd10;
    localparam logic [31:0] SC_SHOW_DEF  = 32'd34;
    localparam logic [31:0] SC_PAUSE_DEF = 32'd50;

    localparam int RD_SEL_W = 4;

endpackage : stat_pkg
`default_nettype wire

// File: rtl/stat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stat_counter
//  Description : One CNT_W-bit event counter with sticky overflow flag.
//                Incrementing from all-ones sets ovf; the count then wraps to
//                0 (SAT=0) or stays at all-ones (SAT=1). clr wins over inc.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous reset, active low
//                inc    - count one event this cycle
//                clr    - synchronous clear of count and ovf
//                hold   - freeze the counter (inc ignored)
//                count  - current count
//                ovf    - sticky overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module stat_counter #(
    parameter int CNT_W = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q,   ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc && !hold) begin
            if (&count_q) begin
                ovf_d   = 1'b1;
                count_d = SAT ? count_q : '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule : stat_counter
`default_nettype wire

// File: rtl/statistic_bank.sv
`default_nettype none
// ============================================================================
//  Module      : statistic_bank
//  Description : Pipeline statistics bank beside WB. Counts run cycles and
//                NUM_EVT event channels, decodes display/halt/pause syscalls
//                and exposes every counter through a registered read port.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous reset, active low
//                A / B        - syscall code ($v0) / data ($a0)
//                syscall_t    - syscall retiring this cycle
//                strong_halt  - unconditional halt request
//                evt_in       - per-channel event strobes
//                clr          - synchronous clear of counters and ovf
//                go           - resume out of PAUSE
//                rd_sel       - 0 = cycle counter, i = channel i-1
//                rd_data      - registered read data (1-cycle latency)
//                ovf          - sticky overflow, bit 0 = cycle counter
//                syscall_out  - last displayed value
//                halt/paused  - current state indicators
//  Revision    : 1.0  initial release
// ============================================================================
module statistic_bank
    import stat_pkg::*;
#(
    parameter int          NUM_EVT  = 4,
    parameter int          CNT_W    = 32,
    parameter bit          SAT      = 1'b0,
    parameter logic [31:0] SC_HALT  = SC_HALT_DEF,
    parameter logic [31:0] SC_SHOW  = SC_SHOW_DEF,
    parameter logic [31:0] SC_PAUSE = SC_PAUSE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    input  logic                syscall_t,
    input  logic                strong_halt,
    input  logic [NUM_EVT-1:0]  evt_in,
    input  logic                clr,
    input  logic                go,
    input  logic [RD_SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic [NUM_EVT:0]    ovf,
    output logic [31:0]         syscall_out,
    output logic                halt,
    output logic                paused
);

    state_e           state_q, state_d;
    logic [31:0]      syscall_out_q, syscall_out_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic             hold;
    logic             sc_halt, sc_show, sc_pause;
    logic [NUM_EVT:0] inc_vec;
    logic [NUM_EVT:0] ovf_vec;
    logic [CNT_W-1:0] cnt [NUM_EVT+1];

    assign hold     = (state_q != ST_RUN);
    assign sc_halt  = syscall_t && (A == SC_HALT);
    assign sc_show  = syscall_t && (A == SC_SHOW);
    assign sc_pause = syscall_t && (A == SC_PAUSE);

    // Slot 0 is the cycle counter, which counts every RUN cycle.
    assign inc_vec  = {evt_in, 1'b1};

    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
        stat_counter #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[g]),
            .clr   (clr),
            .hold  (hold),
            .count (cnt[g]),
            .ovf   (ovf_vec[g])
        );
    end

    // Next state and display latch. Syscalls are decoded only in RUN.
    always_comb begin
        state_d       = state_q;
        syscall_out_d = syscall_out_q;
        case (state_q)
            ST_RUN: begin
                if (strong_halt || sc_halt) begin
                    state_d = ST_HALT;
                end else if (sc_pause) begin
                    state_d = ST_PAUSE;
                end
                if (sc_show) begin
                    syscall_out_d = B;
                end
            end
            ST_PAUSE: begin
                if (strong_halt) begin
                    state_d = ST_HALT;
                end else if (go) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Read mux samples the counter outputs, i.e. the pre-update values.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (rd_sel == RD_SEL_W'(i)) begin
                rd_data_d = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            syscall_out_q <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            syscall_out_q <= syscall_out_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign ovf         = ovf_vec;
    assign syscall_out = syscall_out_q;
    assign halt        = (state_q == ST_HALT);
    assign paused      = (state_q == ST_PAUSE);

endmodule : statistic_bank
`default_nettype wire

// File: tb/tb_statistic_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_statistic_bank
//  Description : Self-checking bench for statistic_bank. A default build plus
//                two 4-bit builds (wrap and saturate) share control inputs.
//                Read expectations are queued when rd_sel is driven and
//                compared when rd_data appears one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_statistic_bank;

    logic        clk;
    logic        rst;
    logic [31:0] A, B;
    logic        syscall_t, strong_halt, clr, go;
    logic [3:0]  evt_in;
    logic        evt_s;
    logic [3:0]  rd_sel, rd_sel_s;

    logic [31:0] rd_data;
    logic [4:0]  ovf;
    logic [31:0] syscall_out;
    logic        halt, paused;

    logic [3:0]  rd_data_w, rd_data_s;
    logic [4:0]  ovf_w, ovf_s;
    logic [31:0] syscall_out_w, syscall_out_s;
    logic        halt_w, halt_s, paused_w, paused_s;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    statistic_bank dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .syscall_t(syscall_t),
        .strong_halt(strong_halt), .evt_in(evt_in), .clr(clr), .go(go),
        .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf),
        .syscall_out(syscall_out), .halt(halt), .paused(paused)
    );

    statistic_bank #(.CNT_W(4), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .A(A), .B(B), .syscall_t(syscall_t),
        .strong_halt(strong_halt), .evt_in({3'b000, evt_s}), .clr(clr), .go(go),
        .rd_sel(rd_sel_s), .rd_data(rd_data_w), .ovf(ovf_w),
        .syscall_out(syscall_out_w), .halt(halt_w), .paused(paused_w)
    );

    statistic_bank #(.CNT_W(4), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .A(A), .B(B), .syscall_t(syscall_t),
        .strong_halt(strong_halt), .evt_in({3'b000, evt_s}), .clr(clr), .go(go),
        .rd_sel(rd_sel_s), .rd_data(rd_data_s), .ovf(ovf_s),
        .syscall_out(syscall_out_s), .halt(halt_s), .paused(paused_s)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] got(input int src);
        case (src)
            0:       return 64'(rd_data);
            1:       return 64'(rd_data_w);
            default: return 64'(rd_data_s);
        endcase
    endfunction

    task automatic expect_rd(input string tag, input int src, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then compare every queued read result.
    task automatic collect();
        sb_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, got(e.src), 64'(e.exp));
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; A = '0; B = '0; syscall_t = 1'b0; strong_halt = 1'b0;
        clr = 1'b0; go = 1'b0; evt_in = '0; evt_s = 1'b0;
        rd_sel = '0; rd_sel_s = '0;

        // Reset state and basic counting
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_halt", halt, 0);
        check("rst_paused", paused, 0);
        check("rst_show", syscall_out, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        evt_in = 4'b0101;
        repeat (20) @(negedge clk);
        evt_in = '0;
        rd_sel = 4'd0;  expect_rd("cnt_cyc", 0, 20);  collect();
        rd_sel = 4'd1;  expect_rd("cnt_ch0", 0, 20);  collect();
        rd_sel = 4'd2;  expect_rd("cnt_ch1", 0, 0);   collect();
        rd_sel = 4'd3;  expect_rd("cnt_ch2", 0, 20);  collect();
        rd_sel = 4'd4;  expect_rd("cnt_ch3", 0, 0);   collect();
        rd_sel = 4'd5;  expect_rd("rd_oob5", 0, 0);   collect();
        rd_sel = 4'd15; expect_rd("rd_oob15", 0, 0);  collect();

        // Overflow on the 4-bit builds
        reset_dut();
        evt_s = 1'b1;
        repeat (15) @(negedge clk);
        check("ovf_w_pre", ovf_w, 0);
        check("ovf_s_pre", ovf_s, 0);
        rd_sel_s = 4'd1;
        expect_rd("w_ch0_15", 1, 15);
        expect_rd("s_ch0_15", 2, 15);
        collect();
        @(negedge clk);
        evt_s = 1'b0;
        check("ovf_w_post", ovf_w, 5'b00011);
        check("ovf_s_post", ovf_s, 5'b00011);
        rd_sel_s = 4'd1;
        expect_rd("w_ch0_wrap", 1, 1);
        expect_rd("s_ch0_sat", 2, 15);
        collect();
        rd_sel_s = 4'd0;
        expect_rd("w_cyc_wrap", 1, 2);
        expect_rd("s_cyc_sat", 2, 15);
        collect();

        // Clear beats a same-cycle increment
        clr = 1'b1; evt_in = 4'hF; evt_s = 1'b1;
        @(negedge clk);
        clr = 1'b0; evt_in = '0; evt_s = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_ovf_w", ovf_w, 0);
        check("clr_ovf_s", ovf_s, 0);
        rd_sel = 4'd0; rd_sel_s = 4'd1;
        expect_rd("clr_cyc", 0, 0);
        expect_rd("clr_w_ch0", 1, 0);
        expect_rd("clr_s_ch0", 2, 0);
        collect();
        rd_sel = 4'd1; expect_rd("clr_ch0", 0, 0); collect();
        rd_sel = 4'd4; expect_rd("clr_ch3", 0, 0); collect();

        // Strong halt, triggering cycle still counted, then async reset
        evt_in = 4'hF;
        repeat (3) @(negedge clk);
        strong_halt = 1'b1;
        @(negedge clk);
        strong_halt = 1'b0; evt_in = '0;
        check("sh_halt", halt, 1);
        check("sh_paused", paused, 0);
        rd_sel = 4'd0; expect_rd("sh_cyc", 0, 7); collect();
        rd_sel = 4'd4; expect_rd("sh_ch3", 0, 4); collect();
        #2 rst = 1'b0;
        #1;
        check("arst_halt", halt, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        rd_sel = 4'd0; expect_rd("arst_cyc", 0, 0); collect();

        // Display then halt by syscall at cycle 30
        reset_dut();
        for (int c = 0; c <= 30; c++) begin
            syscall_t = 1'b0; A = '0; B = '0;
            if (c == 2) begin
                check("show_before", syscall_out, 0);
                syscall_t = 1'b1; A = 32'd34; B = 32'd123;
            end
            if (c == 30) begin
                check("halt_before", halt, 0);
                syscall_t = 1'b1; A = 32'd10;
            end
            @(negedge clk);
        end
        syscall_t = 1'b0;
        check("halt_at31", halt, 1);
        check("show_val", syscall_out, 123);
        syscall_t = 1'b1; A = 32'd34; B = 32'd999;
        @(negedge clk);
        syscall_t = 1'b0; A = '0; B = '0;
        repeat (9) @(negedge clk);
        check("halt_hold", halt, 1);
        check("show_ignored", syscall_out, 123);
        rd_sel = 4'd0; expect_rd("halt_cyc", 0, 31); collect();
        #2 rst = 1'b0;
        #1;
        check("arst2_halt", halt, 0);
        check("arst2_show", syscall_out, 0);
        check("arst2_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Pause at cycle 5, resume by go at cycle 12
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            if (c > 0) check($sformatf("pause_c%0d", c), paused, (c >= 6 && c <= 12) ? 1 : 0);
            evt_in    = 4'b0001;
            go        = (c == 12);
            syscall_t = (c == 5);
            A         = (c == 5) ? 32'd50 : 32'd0;
            @(negedge clk);
        end
        evt_in = '0; go = 1'b0; syscall_t = 1'b0; A = '0;
        check("pause_end", paused, 0);
        rd_sel = 4'd0; expect_rd("pause_cyc", 0, 13); collect();
        rd_sel = 4'd1; expect_rd("pause_ch0", 0, 13); collect();

        // strong_halt beats go in PAUSE; HALT is terminal
        reset_dut();
        syscall_t = 1'b1; A = 32'd50;
        @(negedge clk);
        syscall_t = 1'b0; A = '0;
        check("p2_paused", paused, 1);
        go = 1'b1; strong_halt = 1'b1;
        @(negedge clk);
        go = 1'b0; strong_halt = 1'b0;
        check("p2_halt", halt, 1);
        check("p2_not_paused", paused, 0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("p2_halt_term", halt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_statistic_bank
`default_nettype wire
